// File: rtl/mem_responder_pkg.sv
// Shared types and default build constants for the data-memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int LATENCY_DEF = 4;
  localparam int DEPTH_W_DEF = 13;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: combinational read, synchronous write, contents never reset.
module mem_word_array #(
  parameter int DEPTH_W = 13,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [DEPTH_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency load/store responder: latch request, count down, pulse response.
// state | meaning
// IDLE  | ready for a request
// WAIT  | access latency elapsing, cnt counts down to 1
// RESP  | one-cycle response; writes commit on the edge leaving this state
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH_W = DEPTH_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [DEPTH_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_we;
  logic               unused_addr;

  // Byte-lane bit and bits above the word index do not select storage.
  assign unused_addr = ^{req_addr[0], req_addr >> (DEPTH_W + 1)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          idx_d   = req_addr[DEPTH_W:1];
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_wr    = rsp_valid & wr_q;
  assign rsp_rdata = (rsp_valid && !wr_q) ? mem_rdata : '0;
  assign mem_we    = rsp_valid & wr_q;

  mem_word_array #(
    .DEPTH_W(DEPTH_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk    (clk),
    .wr_en_i(mem_we),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

endmodule
